// File: rtl/sram_pkg.sv
// Shared definitions for the 1RW SRAM model: FSM state codes, write-mask
// expansion and elaboration-time parameter legality checks.
package sram_pkg;

  // Upper bound on entry width supported by the mask expansion helper.
  localparam int unsigned MAX_DATA_W = 1024;
  localparam int unsigned MAX_IDX_W  = 10;

  typedef logic [0:0] state_t;

  localparam state_t ST_CLEAR = 1'b0;
  localparam state_t ST_IDLE  = 1'b1;

  // Geometry is legal when the lane width divides the entry width exactly.
  function automatic bit params_legal(input int unsigned data_w, input int unsigned lane_w);
    return (lane_w != 0) && (data_w != 0) && (data_w <= MAX_DATA_W) &&
           ((data_w % lane_w) == 0);
  endfunction

  // Expand a per-lane mask into a per-bit enable: bit i follows lane i/lane_w.
  function automatic logic [MAX_DATA_W-1:0] expand_mask(input logic [MAX_DATA_W-1:0] mask,
                                                        input int unsigned           lane_w);
    logic [MAX_DATA_W-1:0] bits;
    bits = '0;
    if (lane_w != 0) begin
      for (int unsigned i = 0; i < MAX_DATA_W; i++) begin
        bits[MAX_IDX_W'(i)] = mask[MAX_IDX_W'(i / lane_w)];
      end
    end
    return bits;
  endfunction

endpackage

// File: rtl/sram_1rw_core.sv
// Bare 1RW storage array: synchronous bit-masked write, synchronous read whose
// address is sampled on the read edge into a data register that holds until
// the next read (later writes do not disturb it).
// Ports: clock, reset_n (async, active-low; clears only the read register),
//        wr_en, rd_en, addr, wbits (per-bit write enable), wdata, rdata.
module sram_1rw_core
  import sram_pkg::*;
#(
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned DATA_W = 108
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wbits,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage itself has no reset; the clear engine initialises it.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[addr] <= (wbits & wdata) | (~wbits & mem[addr]);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rdata <= '0;
    end else if (rd_en) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/sram_1rw_clr.sv
// 1RW SRAM with per-lane write mask, valid/ready request port, selectable read
// latency (1 or 2) and a clear engine that fills the array with CLR_VAL after
// reset or on request.
// Ports: clock, reset_n (async, active-low), clear, req_valid/req_ready,
//        req_addr, req_wmode (1=write), req_wmask (per lane), req_wdata,
//        resp_valid, resp_rdata (held between responses), clr_busy.
module sram_1rw_clr
  import sram_pkg::*;
#(
  parameter int unsigned        ADDR_W  = 7,
  parameter int unsigned        DATA_W  = 108,
  parameter int unsigned        LANE_W  = 1,
  parameter int unsigned        OUT_REG = 0,
  parameter logic [DATA_W-1:0]  CLR_VAL = '0,
  localparam int unsigned       MASK_W  = DATA_W / LANE_W
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_wmode,
  input  logic [MASK_W-1:0] req_wmask,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              clr_busy
);

  if (!params_legal(DATA_W, LANE_W)) begin : g_bad_params
    $error("sram_1rw_clr: DATA_W must be a non-zero multiple of LANE_W and <= MAX_DATA_W");
  end

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic              accept;
  logic [DATA_W-1:0] lane_bits;
  logic              core_we, core_re;
  logic [ADDR_W-1:0] core_addr;
  logic [DATA_W-1:0] core_wbits, core_wdata, core_rdata;
  logic              rd_pend_q;

  // Both flags decode straight from the state register, so they switch together.
  assign req_ready = (state_q == ST_IDLE);
  assign clr_busy  = (state_q == ST_CLEAR);
  assign accept    = req_valid & req_ready;
  assign lane_bits = DATA_W'(expand_mask(MAX_DATA_W'(req_wmask), LANE_W));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_CLEAR;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // Next state and array port steering; terminal detect on all-ones stops the
  // clear after exactly one pass.
  always_comb begin
    state_d    = state_q;
    clr_cnt_d  = clr_cnt_q;
    core_we    = 1'b0;
    core_re    = 1'b0;
    core_addr  = req_addr;
    core_wbits = lane_bits;
    core_wdata = req_wdata;
    case (state_q)
      ST_CLEAR: begin
        core_we    = 1'b1;
        core_addr  = clr_cnt_q;
        core_wbits = '1;
        core_wdata = CLR_VAL;
        if (clr_cnt_q == '1) begin
          state_d   = ST_IDLE;
          clr_cnt_d = '0;
        end else begin
          clr_cnt_d = clr_cnt_q + ADDR_W'(1);
        end
      end
      default: begin
        core_we = accept & req_wmode;
        core_re = accept & ~req_wmode;
        // A request accepted alongside clear still executes this cycle.
        if (clear) begin
          state_d   = ST_CLEAR;
          clr_cnt_d = '0;
        end
      end
    endcase
  end

  sram_1rw_core #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_core (
    .clock   (clock),
    .reset_n (reset_n),
    .wr_en   (core_we),
    .rd_en   (core_re),
    .addr    (core_addr),
    .wbits   (core_wbits),
    .wdata   (core_wdata),
    .rdata   (core_rdata)
  );

  // Marks the cycle in which the core read register holds fresh data.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_pend_q <= 1'b0;
    end else begin
      rd_pend_q <= core_re;
    end
  end

  if (OUT_REG == 0) begin : g_lat1
    assign resp_valid = rd_pend_q;
    assign resp_rdata = core_rdata;
  end else begin : g_lat2
    logic              valid2_q;
    logic [DATA_W-1:0] rdata2_q;

    // Extra output stage; data only advances with a response so it holds.
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        valid2_q <= 1'b0;
        rdata2_q <= '0;
      end else begin
        valid2_q <= rd_pend_q;
        if (rd_pend_q) begin
          rdata2_q <= core_rdata;
        end
      end
    end

    assign resp_valid = valid2_q;
    assign resp_rdata = rdata2_q;
  end

endmodule

// File: tb/tb_sram_1rw_clr.sv
// Bench for sram_1rw_clr: two instances share stimulus (lane width 1/latency 1
// with zero clear value, and lane width 9/latency 2 with a patterned clear
// value). A behavioural array model predicts every output each cycle; directed
// steps add hand-computed literal expectations.
module tb_sram_1rw_clr;

  localparam int unsigned AW    = 7;
  localparam int unsigned DW    = 108;
  localparam int unsigned DEPTH = 128;
  localparam int unsigned LW1   = 9;
  localparam int unsigned MW1   = 12;
  localparam logic [DW-1:0] CLR1 = {12{9'h0A5}};

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clear = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_wmode = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [MW1-1:0] mask_b = '0;
  logic [DW-1:0] mask_a;
  logic [DW-1:0] req_wdata = '0;
  logic [1:0]    rdy, val, busy;
  logic [DW-1:0] rd0, rd1;

  int n_checks = 0;
  int n_err    = 0;
  int tcyc     = 0;

  typedef struct {
    int            cyc;
    logic [DW-1:0] data;
  } tv_t;

  // Model state.
  logic [DW-1:0] mm [2][DEPTH];
  tv_t           mq [2][$];
  int            m_left [2];
  logic [1:0]    m_val;
  logic [DW-1:0] m_hold [2];
  int            mcyc = 0;

  tv_t log0[$];
  tv_t log1[$];

  always #5 clk = ~clk;
  always @(posedge clk) tcyc <= tcyc + 1;

  // Instance 0 sees the same write pattern as instance 1, expanded to bits.
  always_comb begin
    mask_a = '0;
    for (int j = 0; j < DW; j++) mask_a[j] = mask_b[4'(j / LW1)];
  end

  sram_1rw_clr #(
    .ADDR_W(AW), .DATA_W(DW), .LANE_W(1), .OUT_REG(0), .CLR_VAL({DW{1'b0}})
  ) u_dut0 (
    .clock(clk), .reset_n(rst_n), .clear(clear), .req_valid(req_valid),
    .req_ready(rdy[0]), .req_addr(req_addr), .req_wmode(req_wmode),
    .req_wmask(mask_a), .req_wdata(req_wdata), .resp_valid(val[0]),
    .resp_rdata(rd0), .clr_busy(busy[0])
  );

  sram_1rw_clr #(
    .ADDR_W(AW), .DATA_W(DW), .LANE_W(LW1), .OUT_REG(1), .CLR_VAL(CLR1)
  ) u_dut1 (
    .clock(clk), .reset_n(rst_n), .clear(clear), .req_valid(req_valid),
    .req_ready(rdy[1]), .req_addr(req_addr), .req_wmode(req_wmode),
    .req_wmask(mask_b), .req_wdata(req_wdata), .resp_valid(val[1]),
    .resp_rdata(rd1), .clr_busy(busy[1])
  );

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : 2;
  endfunction

  function automatic logic [DW-1:0] clr_of(input int d);
    return (d == 0) ? {DW{1'b0}} : CLR1;
  endfunction

  function automatic logic bit_en(input int d, input int j);
    return (d == 0) ? mask_a[j] : mask_b[4'(j / LW1)];
  endfunction

  task automatic chk_int(input string nm, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chkd(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: array contents, clear countdown, and a queue of
  // responses tagged with the cycle they must appear in.
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      for (int d = 0; d < 2; d++) begin
        mq[d].delete();
        m_left[d] = DEPTH;
        m_val[d]  = 1'b0;
        m_hold[d] = '0;
        for (int a = 0; a < DEPTH; a++) mm[d][a] = clr_of(d);
      end
    end else begin
      mcyc++;
      for (int d = 0; d < 2; d++) begin
        m_val[d] = 1'b0;
        if (m_left[d] > 0) begin
          m_left[d]--;
        end else begin
          if (req_valid) begin
            if (req_wmode) begin
              for (int j = 0; j < DW; j++)
                if (bit_en(d, j)) mm[d][req_addr][j] = req_wdata[j];
            end else begin
              mq[d].push_back('{cyc: mcyc + lat_of(d) - 1, data: mm[d][req_addr]});
            end
          end
          if (clear) begin
            m_left[d] = DEPTH;
            for (int a = 0; a < DEPTH; a++) mm[d][a] = clr_of(d);
          end
        end
        if (mq[d].size() != 0 && mq[d][0].cyc == mcyc) begin
          m_val[d]  = 1'b1;
          m_hold[d] = mq[d][0].data;
          void'(mq[d].pop_front());
        end
      end
    end
  end

  // Every-cycle comparison against the model, plus a response log.
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        chk_int($sformatf("ready%0d", d), int'(rdy[d]), int'(m_left[d] == 0));
        chk_int($sformatf("clr_busy%0d", d), int'(busy[d]), int'(m_left[d] != 0));
        chk_int($sformatf("resp_valid%0d", d), int'(val[d]), int'(m_val[d]));
        chkd($sformatf("resp_rdata%0d", d), (d == 0) ? rd0 : rd1, m_hold[d]);
      end
      if (val[0]) log0.push_back('{cyc: tcyc, data: rd0});
      if (val[1]) log1.push_back('{cyc: tcyc, data: rd1});
    end
  end

  task automatic op(input logic wr, input logic [AW-1:0] a, input logic [MW1-1:0] mb,
                    input logic [DW-1:0] wd, input logic clr);
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_wmode = wr;
    req_addr  = a;
    mask_b    = mb;
    req_wdata = wd;
    clear     = clr;
  endtask

  task automatic idle();
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_wmode = 1'b0;
    clear     = 1'b0;
  endtask

  task automatic wait_ready(input string nm);
    int n;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!rdy[0] && n < 400);
    chk_int(nm, n, DEPTH);
    chk_int({nm, "_inst1"}, int'(rdy[1]), 1);
  endtask

  initial begin
    #200000;
    n_err++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    int n0;
    int n;

    // Reset values.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_int("rst_ready0", int'(rdy[0]), 0);
    chk_int("rst_busy0", int'(busy[0]), 1);
    chk_int("rst_valid1", int'(val[1]), 0);
    chkd("rst_rdata0", rd0, {DW{1'b0}});
    chkd("rst_rdata1", rd1, {DW{1'b0}});
    @(posedge clk); #1;
    rst_n = 1'b1;
    wait_ready("ready_after_reset");

    // Read every address after the reset clear.
    log0.delete(); log1.delete();
    op(1'b0, '0, '0, '0, 1'b0);
    n0 = tcyc;
    for (int i = 1; i < DEPTH; i++) op(1'b0, AW'(i), '0, '0, 1'b0);
    idle();
    repeat (3) @(negedge clk);
    chk_int("readall_count0", log0.size(), DEPTH);
    chk_int("readall_count1", log1.size(), DEPTH);
    if (log0.size() > 0) chk_int("readall_first_cyc0", log0[0].cyc, n0 + 1);
    if (log1.size() > 0) chk_int("readall_last_cyc1", log1[log1.size()-1].cyc, n0 + DEPTH + 1);
    chkd("readall_data0", rd0, {DW{1'b0}});
    chkd("readall_data1", rd1, CLR1);

    // Masked write: lane 0 (bits 8:0) cleared, rest stays all-ones.
    op(1'b1, AW'(5), 12'hFFF, {DW{1'b1}}, 1'b0);
    op(1'b1, AW'(5), 12'h001, {DW{1'b0}}, 1'b0);
    op(1'b0, AW'(5), 12'h000, {DW{1'b0}}, 1'b0);
    idle();
    @(negedge clk);
    chk_int("mask_valid0", int'(val[0]), 1);
    chkd("mask_data0", rd0, ~{{(DW-9){1'b0}}, 9'h1FF});
    @(negedge clk);
    chk_int("mask_valid1", int'(val[1]), 1);
    chkd("mask_data1", rd1, ~{{(DW-9){1'b0}}, 9'h1FF});

    // Back-to-back reads of preloaded 1..4.
    for (int k = 1; k <= 4; k++) op(1'b1, AW'(k), 12'hFFF, DW'(k), 1'b0);
    idle();
    log0.delete(); log1.delete();
    op(1'b0, AW'(1), '0, '0, 1'b0);
    n0 = tcyc;
    for (int k = 2; k <= 4; k++) op(1'b0, AW'(k), '0, '0, 1'b0);
    idle();
    repeat (3) @(negedge clk);
    chk_int("b2b_count0", log0.size(), 4);
    chk_int("b2b_count1", log1.size(), 4);
    for (int k = 0; k < 4; k++) begin
      if (k < log1.size()) begin
        chk_int($sformatf("b2b_cyc1_%0d", k), log1[k].cyc, n0 + 2 + k);
        chkd($sformatf("b2b_data1_%0d", k), log1[k].data, DW'(k + 1));
      end
      if (k < log0.size()) begin
        chk_int($sformatf("b2b_cyc0_%0d", k), log0[k].cyc, n0 + 1 + k);
        chkd($sformatf("b2b_data0_%0d", k), log0[k].data, DW'(k + 1));
      end
    end

    // Clear with a simultaneous read of addr 7.
    op(1'b1, AW'(7), 12'hFFF, DW'(8'hAB), 1'b0);
    op(1'b0, AW'(7), '0, '0, 1'b1);
    idle();
    @(negedge clk);
    chk_int("clr_read_valid0", int'(val[0]), 1);
    chkd("clr_read_data0", rd0, DW'(8'hAB));
    n = busy[0] ? 1 : 0;
    while (busy[0] && n < 400) begin
      @(negedge clk);
      if (busy[0]) n++;
    end
    chk_int("clr_busy_cycles", n, DEPTH);
    chkd("clr_read_data1_held", rd1, DW'(8'hAB));
    op(1'b0, AW'(7), '0, '0, 1'b0);
    idle();
    @(negedge clk);
    chkd("after_clr_data0", rd0, {DW{1'b0}});
    @(negedge clk);
    chkd("after_clr_data1", rd1, CLR1);

    // Write-then-read, and held data unaffected by a later write.
    op(1'b1, AW'(3), 12'hFFF, DW'(8'h55), 1'b0);
    op(1'b0, AW'(3), '0, '0, 1'b0);
    op(1'b1, AW'(3), 12'hFFF, DW'(8'h66), 1'b0);
    idle();
    repeat (3) @(negedge clk);
    chkd("hold_data0", rd0, DW'(8'h55));
    chkd("hold_data1", rd1, DW'(8'h55));
    op(1'b0, AW'(3), '0, '0, 1'b0);
    idle();
    repeat (2) @(negedge clk);
    chkd("reread_data1", rd1, DW'(8'h66));

    // Mixed masked writes and reads across the array.
    for (int i = 0; i < 24; i++)
      op(1'b1, AW'(i * 5 + 9), MW1'(i * 263) ^ 12'hA5C, {4{27'(i * 1234567 + 99)}}, 1'b0);
    for (int i = 0; i < 24; i++) op(1'b0, AW'(i * 5 + 9), '0, '0, 1'b0);
    idle();
    repeat (3) @(negedge clk);

    // Reset at clear cycle ~60; a clear pulse inside CLEAR is ignored.
    op(1'b0, AW'(9), '0, '0, 1'b1);
    req_valid = 1'b0;
    idle();
    repeat (29) @(posedge clk);
    #1 clear = 1'b1;
    @(posedge clk); #1 clear = 1'b0;
    repeat (29) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk_int("midclr_rst_busy0", int'(busy[0]), 1);
    chk_int("midclr_rst_ready1", int'(rdy[1]), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    wait_ready("ready_after_midclear_reset");

    // Reset with reads in flight: no response may appear.
    op(1'b0, AW'(3), '0, '0, 1'b0);
    @(posedge clk); #1;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk_int("midread_valid0", int'(val[0]), 0);
      chk_int("midread_valid1", int'(val[1]), 0);
    end
    chkd("midread_rdata1", rd1, {DW{1'b0}});
    @(posedge clk); #1 rst_n = 1'b1;
    wait_ready("ready_after_midread_reset");
    op(1'b0, AW'(3), '0, '0, 1'b0);
    idle();
    @(negedge clk);
    chkd("post_reset_data0", rd0, {DW{1'b0}});
    @(negedge clk);
    chkd("post_reset_data1", rd1, CLR1);

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
